// File: rtl/step_generator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | step_generator_if                                                        |
// | Move-request and STEP/DIR signal bundle between controller and generator.|
// | Optional position_out present when STEP_GEN_POSITION_EN is defined.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface step_generator_if #(
  parameter int SIZE = 16
);
  logic            tick_in;
  logic [SIZE-1:0] steps_in;
  logic            dir_in;
  logic            start_in;
  logic            ready_out;
  logic            step_out;
  logic            dir_out;
  logic            done_out;
  logic [SIZE-1:0] remaining_out;
`ifdef STEP_GEN_POSITION_EN
  logic [31:0]     position_out;

  modport master (
    output tick_in, steps_in, dir_in, start_in,
    input  ready_out, step_out, dir_out, done_out, remaining_out, position_out
  );
  modport slave (
    input  tick_in, steps_in, dir_in, start_in,
    output ready_out, step_out, dir_out, done_out, remaining_out, position_out
  );
`else
  modport master (
    output tick_in, steps_in, dir_in, start_in,
    input  ready_out, step_out, dir_out, done_out, remaining_out
  );
  modport slave (
    input  tick_in, steps_in, dir_in, start_in,
    output ready_out, step_out, dir_out, done_out, remaining_out
  );
`endif
endinterface
`default_nettype wire

// File: rtl/step_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | step_generator                                                           |
// | Turns divider ticks into a bounded STEP/DIR pulse train per loaded move. |
// | Optional macro: STEP_GEN_POSITION_EN adds a signed 32-bit position count.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module step_generator #(
  parameter int SIZE        = 16,
  parameter int PULSE_WIDTH = 4,
  parameter int DIR_SETUP   = 2
) (
  input wire              clk_in,
  input wire              reset_in,
  step_generator_if.slave bus
);

  localparam int c_cnt_w = 16;

  localparam logic [2:0] c_idle      = 3'd0;
  localparam logic [2:0] c_setup     = 3'd1;
  localparam logic [2:0] c_wait_tick = 3'd2;
  localparam logic [2:0] c_pulse     = 3'd3;
  localparam logic [2:0] c_done      = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               step_q, step_d;
  logic               dir_q, dir_d;
  logic               tick_q, tick_d;
  logic [SIZE-1:0]    rem_q, rem_d;
  logic               tick_rise;
`ifdef STEP_GEN_POSITION_EN
  logic [31:0]        pos_q, pos_d;
`endif

  // Divider shares this clock, so a plain one-flop edge detect suffices.
  assign tick_rise = bus.tick_in & ~tick_q;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= c_idle;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      rem_q   <= '0;
`ifdef STEP_GEN_POSITION_EN
      pos_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      rem_q   <= rem_d;
`ifdef STEP_GEN_POSITION_EN
      pos_q   <= pos_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    dir_d   = dir_q;
    tick_d  = bus.tick_in;
    rem_d   = rem_q;
`ifdef STEP_GEN_POSITION_EN
    pos_d   = pos_q;
`endif
    case (state_q)
      c_idle: begin
        if (bus.start_in) begin
          rem_d = bus.steps_in;
          dir_d = bus.dir_in;
          if (bus.steps_in == '0) begin
            state_d = c_done;
          end else begin
            state_d = c_setup;
            cnt_d   = c_cnt_w'(DIR_SETUP);
          end
        end
      end
      c_setup: begin
        // Ticks arriving here are deliberately lost: dir_out is still settling.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= c_cnt_w'(1)) begin
          state_d = c_wait_tick;
        end
      end
      c_wait_tick: begin
        if (tick_rise) begin
          step_d  = 1'b1;
          rem_d   = rem_q - 1'b1;
          cnt_d   = c_cnt_w'(PULSE_WIDTH);
          state_d = c_pulse;
`ifdef STEP_GEN_POSITION_EN
          pos_d   = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
`endif
        end
      end
      c_pulse: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= c_cnt_w'(1)) begin
          step_d  = 1'b0;
          state_d = (rem_q == '0) ? c_done : c_wait_tick;
        end
      end
      c_done: begin
        state_d = c_idle;
      end
      default: begin
        state_d = c_idle;
      end
    endcase
  end

  always_comb begin
    bus.ready_out     = (state_q == c_idle);
    bus.done_out      = (state_q == c_done);
    bus.step_out      = step_q;
    bus.dir_out       = dir_q;
    bus.remaining_out = rem_q;
`ifdef STEP_GEN_POSITION_EN
    bus.position_out  = pos_q;
`endif
  end

endmodule
`default_nettype wire

// File: doc/step_generator.md
# step_generator

Consumes the divided tick stream produced by the clock divider and turns it into a bounded STEP/DIR pulse train for the stepper driver. Sits directly downstream of the divider: each rising edge of the divider output is one step opportunity. A move (step count and direction) is loaded through a start/ready handshake. The block enforces direction setup time and step pulse width, then reports completion.

## Interface
- SIZE, 16: width of step count and remaining counter
- PULSE_WIDTH, 4: clk_in cycles step_out is held high per step (>= 1)
- DIR_SETUP, 2: clk_in cycles between dir_out update and earliest step (>= 1)

- clk_in  input  1  system clock; the divider runs on the same clock
- reset_in  input  1  synchronous, active-high reset
- tick_in  input  1  divider output; each rising edge is one step opportunity
- steps_in  input  SIZE  number of steps for the move
- dir_in  input  1  direction for the move (1 = forward)
- start_in  input  1  move request; accepted when start_in & ready_out at a posedge
- ready_out  output  1  high in IDLE only
- step_out  output  1  step pulse to driver
- dir_out  output  1  direction to driver; held between moves
- done_out  output  1  one-cycle pulse at end of an accepted move
- remaining_out  output  SIZE  steps still to issue
- position_out  output  32  signed absolute position; present only with STEP_GEN_POSITION_EN

## Operation
- Edge detect: tick_q <= tick_in each cycle; tick_rise = tick_in & ~tick_q. No synchronizer (same clock domain).
- States: IDLE, SETUP, WAIT_TICK, PULSE, DONE.
- IDLE: ready_out = 1. On accept: latch steps_in into remaining_out, dir_out <= dir_in. If steps_in == 0 go DONE. Otherwise go SETUP with setup counter = DIR_SETUP.
- SETUP: decrement counter; at zero go WAIT_TICK. tick_rise is ignored here.
- WAIT_TICK: on tick_rise: step_out <= 1, remaining_out <= remaining_out - 1, pulse counter = PULSE_WIDTH, go PULSE.
- PULSE: decrement counter. At expiry: step_out <= 0; go DONE if remaining_out == 0, else WAIT_TICK. tick_rise during PULSE is dropped, not queued. The system must therefore configure a divider period > PULSE_WIDTH + 1.
- DONE: done_out = 1 for this single cycle, then IDLE.
- start_in outside IDLE is ignored. steps_in and dir_in are sampled only at accept.
- remaining_out never underflows: the decrement occurs only in WAIT_TICK with remaining_out >= 1.

## Timing
- Reset values:
  - state IDLE, ready_out 1
  - step_out 0, dir_out 0, done_out 0
  - remaining_out 0, tick_q 0, position_out 0
- Reset takes priority over all events. Reset mid-move aborts: step_out low on the next edge, no done_out, remaining_out cleared.
- Accept at edge A: ready_out low from A; SETUP occupies DIR_SETUP cycles.
- step_out rises on the edge following the cycle in which tick_in first reads high (1-cycle lag) and stays high exactly PULSE_WIDTH cycles.
- Last step: step_out falls and done_out rises on the same edge; ready_out returns 1 cycle later.
- Zero-step move: done_out high the cycle after accept; no step_out activity; dir_out still updated.
- tick_in high for several cycles counts as one rising edge only.

## Configuration
- STEP_GEN_POSITION_EN defined:
  - position_out port exists.
  - Updates +1 (dir_out=1) or -1 (dir_out=0) on each edge where step_out rises.
  - 32-bit two's-complement wrap: 0x7FFFFFFF + 1 -> 0x80000000.
  - Cleared only by reset.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset held 30 cycles -> ready_out=1, step_out=0, dir_out=0, done_out=0, remaining_out=0, position_out=0.
- Divider max 100, PULSE_WIDTH=4, steps_in=3, dir_in=1 -> exactly 3 step_out pulses, each 4 cycles wide, rising 1 cycle after each tick_in rise, about 100 cycles apart. done_out pulses once as the 3rd pulse falls; remaining_out=0, position_out=3.
- steps_in=0 -> no step_out, done_out one cycle after accept, ready_out=1 the cycle after.
- Then steps_in=2, dir_in=0, with a tick_in rise during SETUP -> dir_out=0 immediately, that tick ignored, 2 pulses on following ticks, position_out=1.
- start_in pulsed with steps_in=9 mid-move -> ignored; the move completes with its original count, remaining_out unaffected.
- reset_in asserted during PULSE -> step_out=0 next cycle, no done_out, ready_out=1, remaining_out=0, position_out=0.
